mips_multicycle_control: RTL

Multi-cycle successor to the single-cycle MIPS control decoder. A registered state machine sequences each instruction through fetch, decode, execute, memory and write-back cycles, stalling on a memory-ready handshake. It drives the multicycle datapath's register-enable and mux-select lines directly, including the 4-bit ALU control code, with no separate ALU control unit. Unsupported encodings are flagged, and the block then either halts or skips the instruction, depending on a parameter.

---
 rtl/mips_pkg.sv | 73 +++++++
 rtl/mips_multicycle_control_if.sv | 42 ++++
 rtl/mips_instr_class.sv | 61 ++++++
 rtl/mips_multicycle_control.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, function codes, ALU codes, control-state enum
// and the registered control-word layout used by the multicycle controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1111;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_R_EXEC,
        ST_R_WB,
        ST_I_EXEC,
        ST_I_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_ILLEGAL
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_RTYPE,
        CL_ITYPE,
        CL_MEM,
        CL_BRANCH,
        CL_JUMP,
        CL_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       extCntrl;
        logic [3:0] aluCntrl;
        logic [1:0] pcSource;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// register enables and mux selects out.
interface mips_multicycle_control_if #(
    parameter int ALU_CNTRL_W = 4,
    parameter int STATE_W     = 4
);
    logic [5:0]             op_in;
    logic [5:0]             func_in;
    logic                   mem_ready_in;
    logic                   pcWrite_out;
    logic                   pcWriteCond_out;
    logic                   iorD_out;
    logic                   memRead_out;
    logic                   memWrite_out;
    logic                   irWrite_out;
    logic                   memToReg_out;
    logic                   regDst_out;
    logic                   regWrite_out;
    logic                   ALUSrcA_out;
    logic [1:0]             ALUSrcB_out;
    logic                   extCntrl_out;
    logic [ALU_CNTRL_W-1:0] ALUCntrl_out;
    logic [1:0]             pcSource_out;
    logic                   illegal_out;
    logic [STATE_W-1:0]     state_out;

    modport master (
        input  op_in, func_in, mem_ready_in,
        output pcWrite_out, pcWriteCond_out, iorD_out, memRead_out, memWrite_out,
               irWrite_out, memToReg_out, regDst_out, regWrite_out, ALUSrcA_out,
               ALUSrcB_out, extCntrl_out, ALUCntrl_out, pcSource_out, illegal_out,
               state_out
    );

    modport slave (
        output op_in, func_in, mem_ready_in,
        input  pcWrite_out, pcWriteCond_out, iorD_out, memRead_out, memWrite_out,
               irWrite_out, memToReg_out, regDst_out, regWrite_out, ALUSrcA_out,
               ALUSrcB_out, extCntrl_out, ALUCntrl_out, pcSource_out, illegal_out,
               state_out
    );
endinterface

// File: rtl/mips_instr_class.sv
// Combinational op/func classifier: instruction class, ALU code for the
// execute step, extension mode and a legality flag.
module mips_instr_class
    import mips_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   func,
    output instr_class_e instrClass,
    output logic [3:0]   aluCode,
    output logic         extCntrl,
    output logic         legal
);

    always_comb begin
        instrClass = CL_ILLEGAL;
        aluCode    = ALU_ADD;
        extCntrl   = 1'b0;
        legal      = 1'b0;
        case (op)
            OP_RTYPE: begin
                legal      = 1'b1;
                instrClass = CL_RTYPE;
                case (func)
                    FN_ADD:  aluCode = ALU_ADD;
                    FN_SUB:  aluCode = ALU_SUB;
                    FN_AND:  aluCode = ALU_AND;
                    FN_OR:   aluCode = ALU_OR;
                    FN_SLT:  aluCode = ALU_SLT;
                    FN_NOP:  instrClass = CL_NOP;
                    default: begin
                        legal      = 1'b0;
                        instrClass = CL_ILLEGAL;
                    end
                endcase
            end
            OP_ADDI: begin
                legal = 1'b1; instrClass = CL_ITYPE; aluCode = ALU_ADD; extCntrl = 1'b1;
            end
            OP_ANDI: begin
                legal = 1'b1; instrClass = CL_ITYPE; aluCode = ALU_AND;
            end
            OP_ORI: begin
                legal = 1'b1; instrClass = CL_ITYPE; aluCode = ALU_OR;
            end
            OP_LUI: begin
                legal = 1'b1; instrClass = CL_ITYPE; aluCode = ALU_LUI;
            end
            OP_LW, OP_SW: begin
                legal = 1'b1; instrClass = CL_MEM; aluCode = ALU_ADD; extCntrl = 1'b1;
            end
            OP_BEQ: begin
                legal = 1'b1; instrClass = CL_BRANCH; aluCode = ALU_SUB; extCntrl = 1'b1;
            end
            OP_J: begin
                legal = 1'b1; instrClass = CL_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS controller: registered FSM sequencing fetch/decode/execute/
// memory/write-back, stalling on mem_ready_in, driving datapath controls directly.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int ALU_CNTRL_W     = 4,
    parameter int HALT_ON_ILLEGAL = 1,
    parameter int STATE_W         = 4
) (
    input  logic clk,
    input  logic rst_b,
    mips_multicycle_control_if.master bus
);

    state_e       stateQ;
    state_e       stateNext;
    ctrl_t        ctrlQ;
    ctrl_t        ctrlNext;
    instr_class_e instrClass;
    logic [3:0]   aluCode;
    logic         extCntrl;
    logic         legal;
    logic         fetchReady;

    mips_instr_class uClass (
        .op        (bus.op_in),
        .func      (bus.func_in),
        .instrClass(instrClass),
        .aluCode   (aluCode),
        .extCntrl  (extCntrl),
        .legal     (legal)
    );

    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            ST_RESET:    stateNext = ST_FETCH;
            ST_FETCH:    if (bus.mem_ready_in) stateNext = ST_DECODE;
            ST_DECODE: begin
                if (!legal) begin
                    stateNext = ST_ILLEGAL;
                end else begin
                    case (instrClass)
                        CL_MEM:    stateNext = ST_MEM_ADDR;
                        CL_RTYPE:  stateNext = ST_R_EXEC;
                        CL_ITYPE:  stateNext = ST_I_EXEC;
                        CL_BRANCH: stateNext = ST_BRANCH;
                        CL_JUMP:   stateNext = ST_JUMP;
                        CL_NOP:    stateNext = ST_FETCH;
                        default:   stateNext = ST_ILLEGAL;
                    endcase
                end
            end
            ST_MEM_ADDR: stateNext = (bus.op_in == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (bus.mem_ready_in) stateNext = ST_MEM_WB;
            ST_MEM_WB:   stateNext = ST_FETCH;
            ST_MEM_WR:   if (bus.mem_ready_in) stateNext = ST_FETCH;
            ST_R_EXEC:   stateNext = ST_R_WB;
            ST_R_WB:     stateNext = ST_FETCH;
            ST_I_EXEC:   stateNext = ST_I_WB;
            ST_I_WB:     stateNext = ST_FETCH;
            ST_BRANCH:   stateNext = ST_FETCH;
            ST_JUMP:     stateNext = ST_FETCH;
            ST_ILLEGAL:  stateNext = (HALT_ON_ILLEGAL != 0) ? ST_ILLEGAL : ST_FETCH;
            default:     stateNext = ST_RESET;
        endcase
    end

    // Control word is decoded for the state being entered so it is registered
    // alongside the state; R_WB keeps the ALU code latched on entry to R_EXEC.
    always_comb begin
        ctrlNext = '0;
        case (stateNext)
            ST_FETCH: begin
                ctrlNext.memRead  = 1'b1;
                ctrlNext.aluSrcB  = 2'b01;
                ctrlNext.aluCntrl = ALU_ADD;
            end
            ST_DECODE: begin
                ctrlNext.aluSrcB  = 2'b11;
                ctrlNext.extCntrl = 1'b1;
                ctrlNext.aluCntrl = ALU_ADD;
            end
            ST_MEM_ADDR: begin
                ctrlNext.aluSrcA  = 1'b1;
                ctrlNext.aluSrcB  = 2'b10;
                ctrlNext.extCntrl = 1'b1;
                ctrlNext.aluCntrl = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrlNext.memRead = 1'b1;
                ctrlNext.iorD    = 1'b1;
            end
            ST_MEM_WB: begin
                ctrlNext.regWrite = 1'b1;
                ctrlNext.memToReg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrlNext.memWrite = 1'b1;
                ctrlNext.iorD     = 1'b1;
            end
            ST_R_EXEC: begin
                ctrlNext.aluSrcA  = 1'b1;
                ctrlNext.aluCntrl = aluCode;
            end
            ST_R_WB: begin
                ctrlNext.regWrite = 1'b1;
                ctrlNext.regDst   = 1'b1;
                ctrlNext.aluCntrl = ctrlQ.aluCntrl;
            end
            ST_I_EXEC: begin
                ctrlNext.aluSrcA  = 1'b1;
                ctrlNext.aluSrcB  = 2'b10;
                ctrlNext.extCntrl = extCntrl;
                ctrlNext.aluCntrl = aluCode;
            end
            ST_I_WB:     ctrlNext.regWrite = 1'b1;
            ST_BRANCH: begin
                ctrlNext.aluSrcA     = 1'b1;
                ctrlNext.aluCntrl    = ALU_SUB;
                ctrlNext.pcWriteCond = 1'b1;
                ctrlNext.pcSource    = 2'b01;
            end
            ST_JUMP: begin
                ctrlNext.pcWrite  = 1'b1;
                ctrlNext.pcSource = 2'b10;
            end
            ST_ILLEGAL:  ctrlNext.illegal = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stateQ <= ST_RESET;
            ctrlQ  <= '0;
        end else begin
            stateQ <= stateNext;
            ctrlQ  <= ctrlNext;
        end
    end

    // IR/PC load in FETCH follows the memory handshake in the same cycle.
    assign fetchReady = (stateQ == ST_FETCH) && bus.mem_ready_in;

    assign bus.pcWrite_out     = ctrlQ.pcWrite | fetchReady;
    assign bus.irWrite_out     = fetchReady;
    assign bus.pcWriteCond_out = ctrlQ.pcWriteCond;
    assign bus.iorD_out        = ctrlQ.iorD;
    assign bus.memRead_out     = ctrlQ.memRead;
    assign bus.memWrite_out    = ctrlQ.memWrite;
    assign bus.memToReg_out    = ctrlQ.memToReg;
    assign bus.regDst_out      = ctrlQ.regDst;
    assign bus.regWrite_out    = ctrlQ.regWrite;
    assign bus.ALUSrcA_out     = ctrlQ.aluSrcA;
    assign bus.ALUSrcB_out     = ctrlQ.aluSrcB;
    assign bus.extCntrl_out    = ctrlQ.extCntrl;
    assign bus.ALUCntrl_out    = ALU_CNTRL_W'(ctrlQ.aluCntrl);
    assign bus.pcSource_out    = ctrlQ.pcSource;
    assign bus.illegal_out     = ctrlQ.illegal;
    assign bus.state_out       = STATE_W'(stateQ);

endmodule
